// File: rtl/goto_pkg.sv
// Shared widths, special state codes and FSM encoding for the goto-table lookup.
// Pulled in by the controller and its row comparator.
package goto_pkg;

  localparam int STATE_W = 8;
  localparam int CHARA_W = 4;

  localparam logic [STATE_W-1:0] ROOT_STATE = 8'h00;
  localparam logic [STATE_W-1:0] FAIL_STATE = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_RESP = 2'd2
  } fsm_state_t;

  // A miss from the root stays at the root; any other state falls to FAIL.
  function automatic logic [STATE_W-1:0] miss_state(input logic [STATE_W-1:0] s);
    return (s == ROOT_STATE) ? ROOT_STATE : FAIL_STATE;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/goto_entry_cmp.sv
// Compares one returned goto-table row against the lookup key.
// 'past' flags a row whose state is beyond the key in the ascending table.
module goto_entry_cmp
  import goto_pkg::*;
(
  input  logic [STATE_W-1:0] row_state,
  input  logic [CHARA_W-1:0] row_chara,
  input  logic [STATE_W-1:0] key_state,
  input  logic [CHARA_W-1:0] key_chara,
  output logic               hit,
  output logic               past
);

  assign hit  = (row_state == key_state) && (row_chara == key_chara);
  assign past = (row_state > key_state);

endmodule

// File: rtl/goto_lookup_ctrl.sv
// Linear-scan goto-table lookup controller: walks rows from 0 against a
// one-cycle-latency RAM and returns next state with valid/ready handshakes.
module goto_lookup_ctrl
  import goto_pkg::*;
#(
  parameter int NUM_ENTRIES = 32,
  parameter int ADDR_W      = 5
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                REQ_VALID,
  output logic                REQ_READY,
  input  logic [STATE_W-1:0]  REQ_STATE,
  input  logic [CHARA_W-1:0]  REQ_CHARA,
  output logic [ADDR_W-1:0]   ADDR_G,
  input  logic [STATE_W-1:0]  RAM_CURRENT_STATE_G,
  input  logic [CHARA_W-1:0]  RAM_CHARA,
  input  logic [STATE_W-1:0]  RAM_NEXT_STATE,
  output logic                RSP_VALID,
  input  logic                RSP_READY,
  output logic                RSP_HIT,
  output logic [STATE_W-1:0]  RSP_NEXT_STATE,
  output logic [ADDR_W-1:0]   RSP_ADDR,
  output logic [15:0]         HIT_CNT,
  output logic [15:0]         MISS_CNT
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_ENTRIES - 1);

  fsm_state_t          state_reg, state_next;
  logic [STATE_W-1:0]  key_state_reg, key_state_next;
  logic [CHARA_W-1:0]  key_chara_reg, key_chara_next;
  logic [ADDR_W-1:0]   addr_reg, addr_next;
  logic [ADDR_W-1:0]   cmp_idx_reg, cmp_idx_next;
  logic                cmp_valid_reg, cmp_valid_next;
  logic                rsp_hit_reg, rsp_hit_next;
  logic [STATE_W-1:0]  rsp_next_state_reg, rsp_next_state_next;
  logic [ADDR_W-1:0]   rsp_addr_reg, rsp_addr_next;
  logic [15:0]         hit_cnt_reg, hit_cnt_next;
  logic [15:0]         miss_cnt_reg, miss_cnt_next;

  logic row_hit;
  logic row_past;

  goto_entry_cmp u_entry_cmp (
    .row_state (RAM_CURRENT_STATE_G),
    .row_chara (RAM_CHARA),
    .key_state (key_state_reg),
    .key_chara (key_chara_reg),
    .hit       (row_hit),
    .past      (row_past)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg          <= ST_IDLE;
      key_state_reg      <= '0;
      key_chara_reg      <= '0;
      addr_reg           <= '0;
      cmp_idx_reg        <= '0;
      cmp_valid_reg      <= 1'b0;
      rsp_hit_reg        <= 1'b0;
      rsp_next_state_reg <= '0;
      rsp_addr_reg       <= '0;
      hit_cnt_reg        <= '0;
      miss_cnt_reg       <= '0;
    end else begin
      state_reg          <= state_next;
      key_state_reg      <= key_state_next;
      key_chara_reg      <= key_chara_next;
      addr_reg           <= addr_next;
      cmp_idx_reg        <= cmp_idx_next;
      cmp_valid_reg      <= cmp_valid_next;
      rsp_hit_reg        <= rsp_hit_next;
      rsp_next_state_reg <= rsp_next_state_next;
      rsp_addr_reg       <= rsp_addr_next;
      hit_cnt_reg        <= hit_cnt_next;
      miss_cnt_reg       <= miss_cnt_next;
    end
  end

  always_comb begin
    state_next          = state_reg;
    key_state_next      = key_state_reg;
    key_chara_next      = key_chara_reg;
    addr_next           = addr_reg;
    cmp_idx_next        = cmp_idx_reg;
    cmp_valid_next      = cmp_valid_reg;
    rsp_hit_next        = rsp_hit_reg;
    rsp_next_state_next = rsp_next_state_reg;
    rsp_addr_next       = rsp_addr_reg;
    hit_cnt_next        = hit_cnt_reg;
    miss_cnt_next       = miss_cnt_reg;

    unique case (state_reg)
      ST_IDLE: begin
        if (REQ_VALID) begin
          key_state_next = REQ_STATE;
          key_chara_next = REQ_CHARA;
          addr_next      = '0;
          cmp_valid_next = 1'b0;
          state_next     = ST_SCAN;
        end
      end

      ST_SCAN: begin
        // RAM data lags the address by one cycle, so remember which row it is.
        addr_next      = (addr_reg == LAST_IDX) ? addr_reg : addr_reg + 1'b1;
        cmp_idx_next   = addr_reg;
        cmp_valid_next = 1'b1;
        if (cmp_valid_reg) begin
          if (row_hit) begin
            rsp_hit_next        = 1'b1;
            rsp_next_state_next = RAM_NEXT_STATE;
            rsp_addr_next       = cmp_idx_reg;
            state_next          = ST_RESP;
          end else if (row_past || (cmp_idx_reg == LAST_IDX)) begin
            rsp_hit_next        = 1'b0;
            rsp_next_state_next = miss_state(key_state_reg);
            rsp_addr_next       = '0;
            state_next          = ST_RESP;
          end
        end
      end

      ST_RESP: begin
        if (RSP_READY) begin
          if (rsp_hit_reg) hit_cnt_next  = sat_inc16(hit_cnt_reg);
          else             miss_cnt_next = sat_inc16(miss_cnt_reg);
          state_next = ST_IDLE;
        end
      end

      default: state_next = ST_IDLE;
    endcase
  end

  assign REQ_READY      = (state_reg == ST_IDLE);
  assign RSP_VALID      = (state_reg == ST_RESP);
  assign ADDR_G         = addr_reg;
  assign RSP_HIT        = rsp_hit_reg;
  assign RSP_NEXT_STATE = rsp_next_state_reg;
  assign RSP_ADDR       = rsp_addr_reg;
  assign HIT_CNT        = hit_cnt_reg;
  assign MISS_CNT       = miss_cnt_reg;

endmodule

// File: tb/tb_goto_lookup_ctrl.sv
// Directed bench for goto_lookup_ctrl with a one-cycle-latency table model;
// expected values are hand-derived from the table contents below.
module tb_goto_lookup_ctrl;

  localparam int NUM_ENTRIES = 20;
  localparam int ADDR_W      = 5;

  logic              CLK;
  logic              RST;
  logic              REQ_VALID;
  logic              REQ_READY;
  logic [7:0]        REQ_STATE;
  logic [3:0]        REQ_CHARA;
  logic [ADDR_W-1:0] ADDR_G;
  logic [7:0]        RAM_CURRENT_STATE_G;
  logic [3:0]        RAM_CHARA;
  logic [7:0]        RAM_NEXT_STATE;
  logic              RSP_VALID;
  logic              RSP_READY;
  logic              RSP_HIT;
  logic [7:0]        RSP_NEXT_STATE;
  logic [ADDR_W-1:0] RSP_ADDR;
  logic [15:0]       HIT_CNT;
  logic [15:0]       MISS_CNT;

  logic [7:0] tbl_state [0:31];
  logic [3:0] tbl_chara [0:31];
  logic [7:0] tbl_next  [0:31];

  int total;
  int bad;
  int max_addr;

  goto_lookup_ctrl #(
    .NUM_ENTRIES (NUM_ENTRIES),
    .ADDR_W      (ADDR_W)
  ) dut (
    .CLK                 (CLK),
    .RST                 (RST),
    .REQ_VALID           (REQ_VALID),
    .REQ_READY           (REQ_READY),
    .REQ_STATE           (REQ_STATE),
    .REQ_CHARA           (REQ_CHARA),
    .ADDR_G              (ADDR_G),
    .RAM_CURRENT_STATE_G (RAM_CURRENT_STATE_G),
    .RAM_CHARA           (RAM_CHARA),
    .RAM_NEXT_STATE      (RAM_NEXT_STATE),
    .RSP_VALID           (RSP_VALID),
    .RSP_READY           (RSP_READY),
    .RSP_HIT             (RSP_HIT),
    .RSP_NEXT_STATE      (RSP_NEXT_STATE),
    .RSP_ADDR            (RSP_ADDR),
    .HIT_CNT             (HIT_CNT),
    .MISS_CNT            (MISS_CNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Registered-read table: data for ADDR_G appears one cycle later.
  always @(posedge CLK) begin
    RAM_CURRENT_STATE_G <= tbl_state[ADDR_G];
    RAM_CHARA           <= tbl_chara[ADDR_G];
    RAM_NEXT_STATE      <= tbl_next[ADDR_G];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end else begin
      $display("ok   %s: %0h", tag, obs);
    end
  endtask

  // kind 0: hit/root table, kind 1: early-miss table, kind 2: flat table for full miss
  task automatic fill_table(input int kind);
    for (int i = 0; i < 32; i++) begin
      if (kind == 2) begin
        tbl_state[i] = 8'h03; tbl_chara[i] = 4'h0; tbl_next[i] = 8'h40 + 8'(i);
      end else if (i < 3) begin
        tbl_state[i] = 8'h00; tbl_chara[i] = 4'(i + 1); tbl_next[i] = 8'(i + 1);
      end else if (i == 3 && kind == 0) begin
        tbl_state[i] = 8'h01; tbl_chara[i] = 4'h4; tbl_next[i] = 8'h05;
      end else if (i == 4 && kind == 0) begin
        tbl_state[i] = 8'h01; tbl_chara[i] = 4'h6; tbl_next[i] = 8'h07;
      end else if (i == 3) begin
        tbl_state[i] = 8'h02; tbl_chara[i] = 4'h7; tbl_next[i] = 8'h09;
      end else begin
        tbl_state[i] = 8'h10 + 8'(i); tbl_chara[i] = 4'h0; tbl_next[i] = 8'h20 + 8'(i);
      end
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Accept a request, then count edges until RSP_VALID (bounded).
  task automatic run_req(input logic [7:0] s, input logic [3:0] c, output int edges);
    REQ_STATE = s;
    REQ_CHARA = c;
    REQ_VALID = 1'b1;
    check("accept_ready", 32'(REQ_READY), 32'd1);
    tick();
    REQ_VALID = 1'b0;
    REQ_STATE = 8'hAA;
    REQ_CHARA = 4'h5;
    edges = 0;
    max_addr = int'(ADDR_G);
    while (!RSP_VALID && edges < 200) begin
      tick();
      edges++;
      if (int'(ADDR_G) > max_addr) max_addr = int'(ADDR_G);
    end
  endtask

  task automatic handshake();
    RSP_READY = 1'b1;
    tick();
    RSP_READY = 1'b0;
    check("hs_rsp_valid", 32'(RSP_VALID), 32'd0);
    check("hs_req_ready", 32'(REQ_READY), 32'd1);
  endtask

  int edges;
  int waited;

  initial begin
    total = 0;
    bad = 0;
    RST = 1'b1;
    REQ_VALID = 1'b0;
    REQ_STATE = '0;
    REQ_CHARA = '0;
    RSP_READY = 1'b0;
    fill_table(0);
    repeat (3) tick();
    check("rst_req_ready", 32'(REQ_READY), 32'd1);
    check("rst_addr", 32'(ADDR_G), 32'd0);
    check("rst_rsp_valid", 32'(RSP_VALID), 32'd0);
    check("rst_rsp_hit", 32'(RSP_HIT), 32'd0);
    check("rst_rsp_next", 32'(RSP_NEXT_STATE), 32'd0);
    check("rst_rsp_addr", 32'(RSP_ADDR), 32'd0);
    check("rst_hit_cnt", 32'(HIT_CNT), 32'd0);
    check("rst_miss_cnt", 32'(MISS_CNT), 32'd0);
    RST = 1'b0;
    tick();

    // Hit at row 3, then hold the response for 10 cycles.
    run_req(8'h01, 4'h4, edges);
    check("hit_latency", 32'(edges), 32'd5);
    check("hit_flag", 32'(RSP_HIT), 32'd1);
    check("hit_next", 32'(RSP_NEXT_STATE), 32'h05);
    check("hit_addr", 32'(RSP_ADDR), 32'd3);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp_valid", 32'(RSP_VALID), 32'd1);
      check("bp_hit", 32'(RSP_HIT), 32'd1);
      check("bp_next", 32'(RSP_NEXT_STATE), 32'h05);
      check("bp_addr", 32'(RSP_ADDR), 32'd3);
      check("bp_req_ready", 32'(REQ_READY), 32'd0);
      check("bp_hit_cnt", 32'(HIT_CNT), 32'd0);
    end
    // A pending request during the handshake edge must not be taken on it.
    REQ_VALID = 1'b1;
    REQ_STATE = 8'h01;
    REQ_CHARA = 4'h4;
    handshake();
    REQ_VALID = 1'b0;
    check("bp_hit_cnt_after", 32'(HIT_CNT), 32'd1);
    check("bp_miss_cnt_after", 32'(MISS_CNT), 32'd0);
    tick();

    // Root miss: state 0 with chara F is absent; row 3 (state 1) ends the scan.
    run_req(8'h00, 4'hF, edges);
    check("root_latency", 32'(edges), 32'd5);
    check("root_hit", 32'(RSP_HIT), 32'd0);
    check("root_next", 32'(RSP_NEXT_STATE), 32'h00);
    check("root_addr", 32'(RSP_ADDR), 32'd0);
    handshake();
    check("root_miss_cnt", 32'(MISS_CNT), 32'd1);

    // Early miss: row 3 has state 2 > 1.
    fill_table(1);
    run_req(8'h01, 4'h7, edges);
    check("early_latency", 32'(edges), 32'd5);
    check("early_hit", 32'(RSP_HIT), 32'd0);
    check("early_next", 32'(RSP_NEXT_STATE), 32'hFF);
    check("early_addr", 32'(RSP_ADDR), 32'd0);
    handshake();
    check("early_miss_cnt", 32'(MISS_CNT), 32'd2);

    // Full-table miss: every row state 3 < 5, none matches.
    fill_table(2);
    run_req(8'h05, 4'h2, edges);
    check("full_latency", 32'(edges), 32'(NUM_ENTRIES + 1));
    check("full_max_addr", 32'(max_addr), 32'(NUM_ENTRIES - 1));
    check("full_hit", 32'(RSP_HIT), 32'd0);
    check("full_next", 32'(RSP_NEXT_STATE), 32'hFF);
    handshake();
    check("full_miss_cnt", 32'(MISS_CNT), 32'd3);
    check("full_hit_cnt", 32'(HIT_CNT), 32'd1);

    // Reset in the middle of a scan.
    REQ_STATE = 8'h05;
    REQ_CHARA = 4'h2;
    REQ_VALID = 1'b1;
    tick();
    REQ_VALID = 1'b0;
    waited = 0;
    while (ADDR_G != 5'd7 && waited < 50) begin
      tick();
      waited++;
    end
    check("mid_addr_reached", 32'(ADDR_G), 32'd7);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    check("mid_req_ready", 32'(REQ_READY), 32'd1);
    check("mid_rsp_valid", 32'(RSP_VALID), 32'd0);
    check("mid_addr", 32'(ADDR_G), 32'd0);
    check("mid_hit_cnt", 32'(HIT_CNT), 32'd0);
    check("mid_miss_cnt", 32'(MISS_CNT), 32'd0);
    repeat (25) tick();
    check("mid_no_rsp", 32'(RSP_VALID), 32'd0);

    fill_table(0);
    run_req(8'h01, 4'h6, edges);
    check("post_latency", 32'(edges), 32'd6);
    check("post_hit", 32'(RSP_HIT), 32'd1);
    check("post_next", 32'(RSP_NEXT_STATE), 32'h07);
    check("post_addr", 32'(RSP_ADDR), 32'd4);
    handshake();
    check("post_hit_cnt", 32'(HIT_CNT), 32'd1);
    check("post_miss_cnt", 32'(MISS_CNT), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/goto_lookup_ctrl.md
GOTO_LOOKUP_CTRL -- requirements
Module: goto_lookup_ctrl

Interface
REQ-001 SHALL have parameter NUM_ENTRIES, default 32: number of valid goto-table rows, 2..32.
REQ-002 SHALL have parameter ADDR_W, default 5: goto-table index width.
REQ-003 SHALL have port CLK, input, 1: clock; all state changes on the rising edge.
REQ-004 SHALL have port RST, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have port REQ_VALID, input, 1: lookup request present.
REQ-006 SHALL have port REQ_READY, output, 1: controller idle and able to accept a request.
REQ-007 SHALL have port REQ_STATE, input, 8: current automaton state to look up.
REQ-008 SHALL have port REQ_CHARA, input, 4: input character code.
REQ-009 SHALL have port ADDR_G, output, ADDR_W: goto-table row address.
REQ-010 SHALL have port RAM_CURRENT_STATE_G, input, 8: row current-state field, valid one cycle after ADDR_G.
REQ-011 SHALL have port RAM_CHARA, input, 4: row character field, same timing as RAM_CURRENT_STATE_G.
REQ-012 SHALL have port RAM_NEXT_STATE, input, 8: row next-state field, same timing as RAM_CURRENT_STATE_G.
REQ-013 SHALL have port RSP_VALID, output, 1: response present.
REQ-014 SHALL have port RSP_READY, input, 1: consumer accepts the response.
REQ-015 SHALL have port RSP_HIT, output, 1: matching row found.
REQ-016 SHALL have port RSP_NEXT_STATE, output, 8: resulting state.
REQ-017 SHALL have port RSP_ADDR, output, ADDR_W: index of the matching row, 0 on miss.
REQ-018 SHALL have ports HIT_CNT and MISS_CNT, output, 16 each: saturating lookup statistics.

Function
REQ-019 SHALL implement FSM states IDLE, SCAN, RESP; REQ_READY=1 only in IDLE.
REQ-020 SHALL, in IDLE on REQ_VALID&&REQ_READY, latch REQ_STATE/REQ_CHARA, set ADDR_G=0, enter SCAN.
REQ-021 SHALL, in SCAN, increment ADDR_G by one each cycle, saturating at NUM_ENTRIES-1.
REQ-022 SHALL compare returned row k in the cycle after ADDR_G=k was driven (one-cycle RAM latency), tracking k in an internal compare index.
REQ-023 SHALL declare a hit when RAM_CURRENT_STATE_G==latched state and RAM_CHARA==latched chara; it SHALL then enter RESP with RSP_HIT=1, RSP_NEXT_STATE=RAM_NEXT_STATE, RSP_ADDR=k.
REQ-024 SHALL treat the table as sorted ascending by current state: a compared row with RAM_CURRENT_STATE_G > latched state ends the scan as a miss (early miss).
REQ-025 SHALL end as a miss after comparing row NUM_ENTRIES-1 without a hit.
REQ-026 SHALL, on a miss, drive RSP_HIT=0, RSP_ADDR=0, and RSP_NEXT_STATE=ROOT_STATE (0) if the latched state is 0, else FAIL_STATE (8'hFF).
REQ-027 SHALL give latency: a hit at row i raises RSP_VALID at the (i+2)th edge after the accept edge; a full-table miss at the (NUM_ENTRIES+1)th edge.
REQ-028 SHALL hold RSP_VALID and all RSP_* stable in RESP until RSP_READY=1, then return to IDLE on that edge.
REQ-029 SHALL NOT accept a new request on the edge a response handshakes; the next accept occurs no earlier than the following edge.
REQ-030 SHALL increment HIT_CNT or MISS_CNT by one per completed response handshake, saturating at 16'hFFFF.
REQ-031 SHALL ignore REQ_STATE/REQ_CHARA changes outside the accept edge.

Reset
REQ-032 SHALL, on RST=1 at an edge, force IDLE and drive REQ_READY=1, ADDR_G=0, RSP_VALID=0, RSP_HIT=0, RSP_NEXT_STATE=0, RSP_ADDR=0, HIT_CNT=0, MISS_CNT=0.
REQ-033 SHALL abandon any in-progress scan or pending response on reset, with no counter update.

Structure
REQ-034 SHALL take STATE_W=8, CHARA_W=4, ROOT_STATE=8'h00, FAIL_STATE=8'hFF and the FSM state encoding from a shared package goto_pkg.
REQ-035 SHALL place the row comparator (hit / early-miss decode) in one sub-module goto_entry_cmp.

Verification
REQ-036 SHALL verify a hit: table row 3 = (state 1, chara 4, next 5); request (1,4) -> RSP_HIT=1, RSP_NEXT_STATE=5, RSP_ADDR=3, RSP_VALID at the 5th edge after accept.
REQ-037 SHALL verify the root miss: request (0, chara F) with no such row -> RSP_HIT=0, RSP_NEXT_STATE=0.
REQ-038 SHALL verify early miss: rows 0-2 state 0, row 3 state 2; request (1,x) -> miss, RSP_NEXT_STATE=8'hFF, RSP_VALID at the 5th edge.
REQ-039 SHALL verify backpressure: RSP_READY low 10 cycles -> RSP_* stable, REQ_READY=0, HIT_CNT increments only on the handshake edge.
REQ-040 SHALL verify reset mid-scan: RST at ADDR_G=7 -> next edge IDLE, RSP_VALID=0, counters 0; a subsequent request completes normally.
REQ-041 SHALL verify the full-table miss at row NUM_ENTRIES-1 -> RSP_VALID at edge NUM_ENTRIES+1, and ADDR_G never exceeds NUM_ENTRIES-1.
